// File: rtl/bus_arbiter_pkg.sv
// Shared types and limits for the system-bus round-robin arbiter.
package bus_arbiter_pkg;

   localparam int MAX_MASTERS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACTIVE = 2'd2
   } arbState_t;

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin picker: scans upward from the master after the
// last winner, wrapping around, and reports the first requester it finds.
module bus_rr_picker #(
   parameter int NUM_MASTERS = 4,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] requestVec,
   input  logic [IDX_W-1:0]       lastWinner,
   output logic [NUM_MASTERS-1:0] winnerOneHot,
   output logic [IDX_W-1:0]       winnerIdx,
   output logic                   found
);

   int candidate;

   // Walk the requesters in priority order starting just past the last winner.
   always_comb begin
      winnerOneHot = '0;
      winnerIdx    = '0;
      found        = 1'b0;
      candidate    = 0;
      for (int offset = 1; offset <= NUM_MASTERS; offset++) begin
         candidate = (int'(lastWinner) + offset) % NUM_MASTERS;
         if (!found && requestVec[candidate]) begin
            found                   = 1'b1;
            winnerIdx               = IDX_W'(candidate);
            winnerOneHot[candidate] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter with one turnaround cycle between owners and
// a watchdog that ends stalled transactions with a bus error.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [NUM_MASTERS-1:0]         request_i,
   output logic [NUM_MASTERS-1:0]         grant_o,
   output logic [$clog2(NUM_MASTERS)-1:0] owner_o,
   input  logic                           bus_beginTransaction_i,
   input  logic                           bus_endTransaction_i,
   input  logic                           bus_dataValid_i,
   input  logic                           bus_busy_i,
   input  logic                           bus_error_i,
   output logic                           bus_endTransaction_o,
   output logic                           bus_error_o
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_FULL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arbState_t              state;
   logic [IDX_W-1:0]       lastWinner;
   logic [CNT_W-1:0]       quietCount;
   logic [NUM_MASTERS-1:0] pickOneHot;
   logic [IDX_W-1:0]       pickIdx;
   logic                   pickFound;
   logic                   slaveDone;

   assign slaveDone = bus_endTransaction_i | bus_error_i;

   bus_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) picker (
      .requestVec   (request_i),
      .lastWinner   (lastWinner),
      .winnerOneHot (pickOneHot),
      .winnerIdx    (pickIdx),
      .found        (pickFound)
   );

   // Arbitration FSM, watchdog counter and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state                <= IDLE;
         grant_o              <= '0;
         owner_o              <= '0;
         lastWinner           <= IDX_W'(NUM_MASTERS - 1);
         quietCount           <= '0;
         bus_endTransaction_o <= 1'b0;
         bus_error_o          <= 1'b0;
      end else begin
         bus_endTransaction_o <= 1'b0;
         bus_error_o          <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pickFound) begin
                  grant_o    <= pickOneHot;
                  owner_o    <= pickIdx;
                  lastWinner <= pickIdx;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (bus_beginTransaction_i) begin
                  if (slaveDone) begin
                     grant_o <= '0;
                     state   <= IDLE;
                  end else begin
                     quietCount <= '0;
                     state      <= ACTIVE;
                  end
               end else if (!request_i[owner_o]) begin
                  grant_o <= '0;
                  state   <= IDLE;
               end
            end
            ACTIVE: begin
               // A full count means the strobes went out last cycle, so the
               // counter never has to move past TIMEOUT_FULL.
               if (slaveDone || quietCount == TIMEOUT_FULL) begin
                  grant_o    <= '0;
                  quietCount <= '0;
                  state      <= IDLE;
               end else if (bus_dataValid_i || bus_busy_i) begin
                  quietCount <= '0;
               end else begin
                  quietCount <= quietCount + 1'b1;
                  if (quietCount == TIMEOUT_LAST) begin
                     bus_endTransaction_o <= 1'b1;
                     bus_error_o          <= 1'b1;
                  end
               end
            end
            default: begin
               grant_o <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single-core system bus between up to 32 bus masters (CPU instruction/data ports, DMA, debug) in front of the memory-mapped slaves. Grants exactly one master at a time, holds the grant from `beginTransaction` until `endTransaction`, and releases it with one turnaround cycle. A watchdog terminates stalled transactions with a bus error, so a missing or hung slave cannot lock the bus.

## Interface
- `NUM_MASTERS`, 4, number of requesters, 2..32
- `TIMEOUT_CYCLES`, 256, idle cycles tolerated inside a transaction before the watchdog fires, ≥2
- `clk_i` in 1: single system clock, all logic on rising edge
- `rst_n_i` in 1: reset, asynchronous, active-low
- `request_i` in NUM_MASTERS: per-master bus request, level, held until granted transaction ends
- `grant_o` out NUM_MASTERS: one-hot-or-zero registered grant
- `owner_o` out $clog2(NUM_MASTERS): index of granted master, valid while `|grant_o`
- `bus_beginTransaction_i` in 1: begin strobe of the granted master
- `bus_endTransaction_i` in 1: OR of all end strobes on the bus
- `bus_dataValid_i` in 1: OR of all data-valid strobes on the bus
- `bus_busy_i` in 1: OR of slave busy
- `bus_error_i` in 1: OR of slave error
- `bus_endTransaction_o` out 1: arbiter-driven end strobe (watchdog only), ORed onto bus
- `bus_error_o` out 1: arbiter-driven error strobe (watchdog only), ORed onto bus

## Operation
- States: IDLE, GRANT (granted, awaiting begin), ACTIVE (transaction running).
- IDLE: if any `request_i` set, pick winner = first set bit searching upward from `last_winner+1` modulo NUM_MASTERS; register `grant_o`/`owner_o`, store `last_winner`, go to GRANT. No request: stay, `grant_o`=0.
- GRANT: `bus_beginTransaction_i` → ACTIVE, watchdog cleared. Granted master drops request without begin → IDLE, grant cleared. Begin and `bus_endTransaction_i`/`bus_error_i` in the same cycle → IDLE.
- ACTIVE: `bus_endTransaction_i` or `bus_error_i` → IDLE, grant cleared. Requests from other masters ignored; request changes of owner ignored.
- Watchdog (ACTIVE only): counter clears on any cycle with `bus_dataValid_i` or `bus_busy_i`, else increments. Reaching TIMEOUT_CYCLES → assert `bus_endTransaction_o` and `bus_error_o` for exactly one cycle, go to IDLE. Counter width $clog2(TIMEOUT_CYCLES+1), saturates, never wraps.
- Watchdog firing and slave end in the same cycle: slave end wins, arbiter strobes stay low.
- `last_winner` reset value NUM_MASTERS-1, so master 0 has first priority after reset.

## Timing
- Reset (async assert, sync release): state IDLE, `grant_o`=0, `owner_o`=0, `bus_endTransaction_o`=0, `bus_error_o`=0, counter 0. Reset mid-transaction drops grant immediately.
- Request → grant latency: 1 cycle (request sampled at edge n in IDLE, `grant_o` high after edge n).
- End → grant low: 1 cycle. End → next grant: 2 cycles (one mandatory turnaround cycle with `grant_o`=0).
- Watchdog strobe: asserted after TIMEOUT_CYCLES consecutive quiet ACTIVE cycles; grant low the cycle after.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package `bus_arbiter_pkg`: state enum (IDLE, GRANT, ACTIVE), `MAX_MASTERS`=32.
- Sub-module `bus_rr_picker`: combinational round-robin picker (request vector, last winner → one-hot winner, index, found flag). Rest (FSM, watchdog, output registers) in `bus_arbiter`.

## Test plan
- Reset, then `request_i`=4'b1111 held, each transaction begin→end after 3 cycles → grants in order 0,1,2,3,0 with one `grant_o`=0 cycle between each.
- `request_i`=4'b0100 only → `grant_o`=4'b0100 one cycle later, `owner_o`=2; end strobe → grant 0 next cycle.
- Granted master 1 drops request in GRANT without begin → IDLE next cycle, master 2 (requesting) granted the cycle after.
- TIMEOUT_CYCLES=8, begin then no valid/busy/end → `bus_endTransaction_o`=`bus_error_o`=1 for exactly one cycle on the 8th quiet cycle, grant low next cycle.
- Same setup, `bus_dataValid_i` pulse every 5 cycles for 40 cycles → watchdog never fires; slave end on the cycle the count would hit 8 → arbiter strobes stay 0.
- Assert `rst_n_i`=0 mid-ACTIVE → `grant_o`=0 without a clock edge; after release master 0 wins first.
